// File: rtl/ethpipe_pkg.sv
// Shared definitions for the ethpipe RX slot drain: slot word map,
// drain state encoding and the beat record carried through the buffer.
package ethpipe_pkg;

  localparam int SLOT_AW = 11;

  localparam logic [SLOT_AW-1:0] SLOT_TS_LO = 11'd1;
  localparam logic [SLOT_AW-1:0] SLOT_TS_HI = 11'd2;
  localparam logic [SLOT_AW-1:0] SLOT_HASH  = 11'd3;
  localparam logic [SLOT_AW-1:0] SLOT_LEN   = 11'd4;
  localparam logic [SLOT_AW-1:0] SLOT_DATA  = 11'd5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CHECK   = 2'd1,
    ST_STREAM  = 2'd2,
    ST_RELEASE = 2'd3
  } drain_state_t;

  typedef struct packed {
    logic [31:0] data;
    logic        sop;
    logic        eop;
    logic [1:0]  last_bytes;
  } beat_t;

  // Address of the final slot word for a frame of len bytes (11-bit wrap).
  function automatic logic [SLOT_AW-1:0] last_word_addr(input logic [SLOT_AW-1:0] len);
    return SLOT_LEN + ((len + 11'd3) >> 2);
  endfunction

endpackage

// File: rtl/ethpipe_rx_drain_if.sv
// Valid/ready stream carrying slot records toward the DMA/host stage.
interface ethpipe_rx_drain_if;
  logic [31:0] rx_tdata;
  logic        rx_tvalid;
  logic        rx_tready;
  logic        rx_tsop;
  logic        rx_teop;
  logic [1:0]  rx_tlast_bytes;

  modport master (
    output rx_tdata, rx_tvalid, rx_tsop, rx_teop, rx_tlast_bytes,
    input  rx_tready
  );

  modport slave (
    input  rx_tdata, rx_tvalid, rx_tsop, rx_teop, rx_tlast_bytes,
    output rx_tready
  );
endinterface

// File: rtl/ethpipe_skid2.sv
// Two-entry valid/ready buffer. The producer throttles itself using the
// occupancy count, so a push always finds room; entry 0 drives the output
// directly and therefore holds stable while the consumer stalls.
module ethpipe_skid2
  import ethpipe_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  beat_t      in_beat,
  output logic [1:0] count,
  output logic       out_valid,
  output beat_t      out_beat,
  input  logic       out_ready
);

  beat_t      ent0;
  beat_t      ent1;
  logic [1:0] cnt;
  logic       push;
  logic       pop;

  assign push      = in_valid;
  assign pop       = (cnt != 2'd0) && out_ready;
  assign out_valid = (cnt != 2'd0);
  assign out_beat  = ent0;
  assign count     = cnt;

  // Storage shift and occupancy update for push/pop combinations.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent0 <= '0;
      ent1 <= '0;
      cnt  <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt == 2'd0) begin
            ent0 <= in_beat;
            cnt  <= 2'd1;
          end else if (cnt == 2'd1) begin
            ent1 <= in_beat;
            cnt  <= 2'd2;
          end
        end
        2'b01: begin
          ent0 <= ent1;
          cnt  <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) begin
            ent0 <= in_beat;
          end else begin
            ent0 <= ent1;
            ent1 <= in_beat;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ethpipe_rx_drain.sv
// Drains one ethpipe RX slot: checks the stored length, streams the slot
// record as 32-bit beats with backpressure, then frees the slot.
module ethpipe_rx_drain
  import ethpipe_pkg::*;
#(
  parameter int MAX_FRAME_LEN = 1522,
  parameter int MIN_FRAME_LEN = 14
) (
  input  logic               pci_clk,
  input  logic               sys_rst,
  input  logic               slot_rx_complete,
  output logic               slot_rx_empty,
  output logic [SLOT_AW-1:0] slot_rx_rd_address,
  input  logic [31:0]        slot_rx_q,
  ethpipe_rx_drain_if.master rx,
  output logic [31:0]        rx_frame_count,
  output logic [31:0]        rx_drop_count,
  output logic [31:0]        rx_overrun_count
);

  drain_state_t       state;
  drain_state_t       state_next;
  logic               chk_phase_p1;
  logic [SLOT_AW-1:0] len;
  logic [SLOT_AW-1:0] len_in;
  logic [SLOT_AW-1:0] last_addr;
  logic               len_ok;
  logic               len_done;
  logic               issue_done;
  logic               issue;
  logic               issue_last;
  logic               rd_vld_p1;
  logic               rd_sop_p1;
  logic               rd_eop_p1;
  logic [1:0]         fifo_cnt;
  logic [2:0]         occ_after;
  logic               out_valid;
  logic               pop;
  logic               eop_pop;
  beat_t              push_beat;
  beat_t              out_beat;

  assign len_in    = slot_rx_q[SLOT_AW-1:0];
  assign len_ok    = (int'(len_in) >= MIN_FRAME_LEN) && (int'(len_in) <= MAX_FRAME_LEN);
  assign len_done  = (state == ST_CHECK) && chk_phase_p1;
  assign last_addr = last_word_addr(len);

  assign pop     = out_valid && rx.rx_tready;
  assign eop_pop = pop && out_beat.eop;

  // Words in flight plus buffered, after this cycle's pop; a new read may
  // only be issued if it will still find a free buffer entry on arrival.
  assign occ_after  = {1'b0, fifo_cnt} + {2'b00, rd_vld_p1} - {2'b00, pop};
  assign issue      = (state == ST_STREAM) && !issue_done && (occ_after <= 3'd1);
  assign issue_last = issue && (slot_rx_rd_address == last_addr);

  assign slot_rx_empty = (state == ST_IDLE);

  // Next-state selection for the drain sequence.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:    if (slot_rx_complete) state_next = ST_CHECK;
      ST_CHECK:   if (len_done) state_next = len_ok ? ST_STREAM : ST_RELEASE;
      ST_STREAM:  if (eop_pop) state_next = ST_RELEASE;
      ST_RELEASE: state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // State register, length capture, read address and read tagging.
  always_ff @(posedge pci_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state              <= ST_IDLE;
      chk_phase_p1       <= 1'b0;
      len                <= '0;
      slot_rx_rd_address <= '0;
      issue_done         <= 1'b0;
      rd_vld_p1          <= 1'b0;
      rd_sop_p1          <= 1'b0;
      rd_eop_p1          <= 1'b0;
    end else begin
      state        <= state_next;
      chk_phase_p1 <= (state == ST_CHECK) && !chk_phase_p1;
      rd_vld_p1    <= issue;
      rd_sop_p1    <= issue && (slot_rx_rd_address == SLOT_TS_LO);
      rd_eop_p1    <= issue_last;
      if (state == ST_IDLE && slot_rx_complete) begin
        slot_rx_rd_address <= SLOT_LEN;
      end
      if (len_done) begin
        len                <= len_in;
        issue_done         <= 1'b0;
        slot_rx_rd_address <= SLOT_TS_LO;
      end
      if (issue) begin
        if (issue_last) issue_done <= 1'b1;
        else            slot_rx_rd_address <= slot_rx_rd_address + 11'd1;
      end
    end
  end

  // Frame, drop and overrun statistics.
  always_ff @(posedge pci_clk or posedge sys_rst) begin
    if (sys_rst) begin
      rx_frame_count   <= '0;
      rx_drop_count    <= '0;
      rx_overrun_count <= '0;
    end else begin
      if (eop_pop)                                rx_frame_count   <= rx_frame_count + 32'd1;
      if (len_done && !len_ok)                    rx_drop_count    <= rx_drop_count + 32'd1;
      if (slot_rx_complete && state != ST_IDLE)   rx_overrun_count <= rx_overrun_count + 32'd1;
    end
  end

  assign push_beat.data       = slot_rx_q;
  assign push_beat.sop        = rd_sop_p1;
  assign push_beat.eop        = rd_eop_p1;
  assign push_beat.last_bytes = rd_eop_p1 ? len[1:0] : 2'd0;

  ethpipe_skid2 u_skid (
    .clk       (pci_clk),
    .rst       (sys_rst),
    .in_valid  (rd_vld_p1),
    .in_beat   (push_beat),
    .count     (fifo_cnt),
    .out_valid (out_valid),
    .out_beat  (out_beat),
    .out_ready (rx.rx_tready)
  );

  assign rx.rx_tvalid      = out_valid;
  assign rx.rx_tdata       = out_beat.data;
  assign rx.rx_tsop        = out_beat.sop;
  assign rx.rx_teop        = out_beat.eop;
  assign rx.rx_tlast_bytes = out_beat.last_bytes;

endmodule

// File: tb/tb_ethpipe_rx_drain.sv
// Directed bench for ethpipe_rx_drain: a slot RAM model with one-cycle read
// latency, a table of frame records, and per-beat checking of the stream.
module tb_ethpipe_rx_drain;

  logic        pci_clk = 1'b0;
  logic        sys_rst;
  logic        slot_rx_complete;
  logic        slot_rx_empty;
  logic [10:0] slot_rx_rd_address;
  logic [31:0] slot_rx_q;
  logic [31:0] rx_frame_count;
  logic [31:0] rx_drop_count;
  logic [31:0] rx_overrun_count;

  ethpipe_rx_drain_if rxi ();

  ethpipe_rx_drain dut (
    .pci_clk            (pci_clk),
    .sys_rst            (sys_rst),
    .slot_rx_complete   (slot_rx_complete),
    .slot_rx_empty      (slot_rx_empty),
    .slot_rx_rd_address (slot_rx_rd_address),
    .slot_rx_q          (slot_rx_q),
    .rx                 (rxi.master),
    .rx_frame_count     (rx_frame_count),
    .rx_drop_count      (rx_drop_count),
    .rx_overrun_count   (rx_overrun_count)
  );

  always #4 pci_clk = ~pci_clk;

  logic [31:0] mem [0:2047];

  always @(posedge pci_clk) slot_rx_q <= mem[slot_rx_rd_address];

  int checks = 0;
  int errors = 0;
  int exp_frames = 0;
  int exp_drops = 0;
  int exp_ovr = 0;

  typedef struct {
    logic [10:0] len;
    bit          rnd;
    int          ovr_beat;
    int          rst_beat;
    int          exp_beats;
    logic [1:0]  exp_lb;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_empty"},    {31'd0, slot_rx_empty}, 32'd1);
    check({tag, "_addr"},     {21'd0, slot_rx_rd_address}, 32'd0);
    check({tag, "_tdata"},    rxi.rx_tdata, 32'd0);
    check({tag, "_tvalid"},   {31'd0, rxi.rx_tvalid}, 32'd0);
    check({tag, "_tsop"},     {31'd0, rxi.rx_tsop}, 32'd0);
    check({tag, "_teop"},     {31'd0, rxi.rx_teop}, 32'd0);
    check({tag, "_lastb"},    {30'd0, rxi.rx_tlast_bytes}, 32'd0);
    check({tag, "_frames"},   rx_frame_count, 32'd0);
    check({tag, "_drops"},    rx_drop_count, 32'd0);
    check({tag, "_overruns"}, rx_overrun_count, 32'd0);
  endtask

  task automatic run_frame(input vec_t v, input int seed);
    int          beats = 0;
    int          cyc;
    int          eop_cyc = -1;
    int          first_v = -1;
    bit          done = 0;
    bit          ovr_sent = 0;
    bit          saw_v = 0;
    bit          hold = 0;
    bit          aborted = 0;
    bit          good;
    logic [31:0] hd = '0;
    logic        hs = 1'b0;
    logic        he = 1'b0;
    logic [1:0]  hl = 2'd0;
    logic [7:0]  sb;
    logic [15:0] ab;
    good = (v.exp_beats > 0);
    sb = seed[7:0];
    for (int a = 1; a < 400; a++) begin
      ab = a[15:0];
      mem[a] = {sb, 8'hC3, ab} ^ 32'h0F0F_0000;
    end
    mem[4] = {21'd0, v.len};
    rxi.rx_tready = 1'b1;
    @(negedge pci_clk);
    slot_rx_complete = 1'b1;
    @(negedge pci_clk);
    slot_rx_complete = 1'b0;
    cyc = 1;
    check("empty_fall_cycle1", {31'd0, slot_rx_empty}, 32'd0);
    while (!done && cyc < 3000) begin
      slot_rx_complete = 1'b0;
      if (v.ovr_beat >= 0 && !ovr_sent && beats == v.ovr_beat) begin
        slot_rx_complete = 1'b1;
        ovr_sent = 1;
        exp_ovr++;
      end
      if (v.rst_beat >= 0 && beats == v.rst_beat && rxi.rx_tvalid) begin
        #2 sys_rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        aborted = 1;
        done = 1;
      end else begin
        rxi.rx_tready = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (hold) begin
          check("stall_tvalid", {31'd0, rxi.rx_tvalid}, 32'd1);
          check("stall_tdata", rxi.rx_tdata, hd);
          check("stall_flags", {29'd0, rxi.rx_tsop, rxi.rx_teop, rxi.rx_tlast_bytes[1]},
                {29'd0, hs, he, hl[1]});
          check("stall_lastb", {30'd0, rxi.rx_tlast_bytes}, {30'd0, hl});
        end
        if (rxi.rx_tvalid) begin
          saw_v = 1;
          if (first_v < 0) first_v = cyc;
        end
        if (rxi.rx_tvalid && rxi.rx_tready) begin
          beats++;
          check("beat_data", rxi.rx_tdata, (beats < 2048) ? mem[beats] : 32'hDEAD_BEEF);
          check("beat_sop", {31'd0, rxi.rx_tsop}, {31'd0, beats == 1});
          check("beat_eop", {31'd0, rxi.rx_teop}, {31'd0, beats == v.exp_beats});
          if (rxi.rx_teop) begin
            check("eop_lastb", {30'd0, rxi.rx_tlast_bytes}, {30'd0, v.exp_lb});
            eop_cyc = cyc;
          end
        end
        hold = rxi.rx_tvalid && !rxi.rx_tready;
        hd = rxi.rx_tdata;
        hs = rxi.rx_tsop;
        he = rxi.rx_teop;
        hl = rxi.rx_tlast_bytes;
        if (eop_cyc >= 0 && cyc == eop_cyc + 1)
          check("empty_low_eop_plus1", {31'd0, slot_rx_empty}, 32'd0);
        if (eop_cyc >= 0 && cyc == eop_cyc + 2) begin
          check("empty_high_eop_plus2", {31'd0, slot_rx_empty}, 32'd1);
          done = 1;
        end
        if (!good && slot_rx_empty) begin
          check("drop_release_le5", {31'd0, cyc <= 5}, 32'd1);
          done = 1;
        end
      end
      if (!done) begin
        @(negedge pci_clk);
        cyc++;
      end
    end
    slot_rx_complete = 1'b0;
    if (!done) check("frame_timeout", 32'd0, 32'd1);
    if (aborted) begin
      @(negedge pci_clk);
      check_reset_outputs("rst_held");
      sys_rst = 1'b0;
      exp_frames = 0;
      exp_drops = 0;
      exp_ovr = 0;
    end else begin
      if (good) exp_frames++;
      else      exp_drops++;
      check("beat_count", beats, v.exp_beats);
      check("any_tvalid", {31'd0, saw_v}, {31'd0, good});
      if (good) check("first_valid_le6", {31'd0, first_v <= 6}, 32'd1);
      check("frame_count", rx_frame_count, exp_frames);
      check("drop_count", rx_drop_count, exp_drops);
      check("overrun_count", rx_overrun_count, exp_ovr);
    end
    rxi.rx_tready = 1'b1;
    @(negedge pci_clk);
  endtask

  initial begin
    //            len   rnd ovr  rst  beats lastb
    vecs[0]  = '{11'd64,   0, -1, -1, 20,  2'd0};
    vecs[1]  = '{11'd61,   0, -1, -1, 20,  2'd1};
    vecs[2]  = '{11'd62,   0, -1, -1, 20,  2'd2};
    vecs[3]  = '{11'd1522, 1, -1, -1, 385, 2'd2};
    vecs[4]  = '{11'd2000, 0, -1, -1, 0,   2'd0};
    vecs[5]  = '{11'd13,   0, -1, -1, 0,   2'd0};
    vecs[6]  = '{11'd64,   0,  5, -1, 20,  2'd0};
    vecs[7]  = '{11'd14,   1, -1, -1, 8,   2'd2};
    vecs[8]  = '{11'd1523, 0, -1, -1, 0,   2'd0};
    vecs[9]  = '{11'd64,   0, -1,  6, 20,  2'd0};
    vecs[10] = '{11'd64,   1, -1, -1, 20,  2'd0};
    vecs[11] = '{11'd15,   0, -1, -1, 8,   2'd3};

    for (int a = 0; a < 2048; a++) mem[a] = 32'd0;
    sys_rst = 1'b1;
    slot_rx_complete = 1'b0;
    rxi.rx_tready = 1'b0;
    repeat (3) @(negedge pci_clk);
    check_reset_outputs("por");
    sys_rst = 1'b0;
    @(negedge pci_clk);
    check("idle_empty", {31'd0, slot_rx_empty}, 32'd1);

    for (int i = 0; i < 12; i++) run_frame(vecs[i], i + 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
